psd_accumulator: RTL and testbench

- Consumer side of the PSD bin counter. It takes the pass-through sample stream plus the counter's sideband (addr, first_cycle, last_cycle) and read-modify-writes a per-bin sum into a dual-port accumulation BRAM.
- On the last cycle of an averaging run, it streams the final per-bin sums out on an AXI-Stream master.
- Sits between the counter and the DMA/readout BRAM in the PSD chain.

---
 rtl/psd_accumulator.sv | 133 +++++++++++++
 tb/tb_psd_accumulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/psd_accumulator.sv
// PSD bin accumulator: read-modify-writes per-bin sums into a dual-port BRAM
// and streams the final sums of an averaging run out on AXI-Stream.
module psd_accumulator #(
  parameter int unsigned PERIOD       = 256,
  parameter int unsigned PERIOD_WIDTH = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned BRAM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PERIOD_WIDTH+1:0] addr,
  input  logic                    first_cycle,
  input  logic                    last_cycle,
  output logic [PERIOD_WIDTH+1:0] bram_raddr,
  input  logic [ACC_WIDTH-1:0]    bram_rdata,
  output logic [PERIOD_WIDTH+1:0] bram_waddr,
  output logic [ACC_WIDTH-1:0]    bram_wdata,
  output logic                    bram_we,
  output logic                    m_axis_tvalid,
  output logic [ACC_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    overflow
);

  localparam int unsigned ADDR_W = PERIOD_WIDTH + 2;
  localparam int unsigned TAP    = BRAM_LATENCY - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic                      s0_valid;
  logic [DATA_WIDTH-1:0]     s0_data;
  logic [PERIOD_WIDTH-1:0]   s0_bin;
  logic                      accept;

  logic [BRAM_LATENCY-1:0]   dl_valid, dl_first, dl_last;
  logic [DATA_WIDTH-1:0]     dl_data [BRAM_LATENCY];
  logic [ADDR_W-1:0]         dl_addr [BRAM_LATENCY];

  logic [ACC_WIDTH:0]        sum_wide;
  logic [ACC_WIDTH-1:0]      sum_sat;
  logic                      sum_ovf;
  logic                      out_bin_last;

  assign s0_bin = addr[ADDR_W-1:2];

  // Read address is the sideband itself so rdata lines up with the delay line tap.
  assign bram_raddr = aresetn ? addr : '0;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Only a first-cycle bin-0 beat arms the block; everything before it is discarded.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (s0_valid && first_cycle && (s0_bin == '0)) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN:     accept = s0_valid;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      dl_valid <= '0;
      dl_first <= '0;
      dl_last  <= '0;
      for (int unsigned i = 0; i < BRAM_LATENCY; i++) begin
        dl_data[i] <= '0;
        dl_addr[i] <= '0;
      end
    end else begin
      s0_valid    <= s_axis_tvalid;
      s0_data     <= s_axis_tdata;
      dl_valid[0] <= accept;
      dl_first[0] <= first_cycle;
      dl_last[0]  <= last_cycle;
      dl_data[0]  <= s0_data;
      dl_addr[0]  <= addr;
      for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_first[i] <= dl_first[i-1];
        dl_last[i]  <= dl_last[i-1];
        dl_data[i]  <= dl_data[i-1];
        dl_addr[i]  <= dl_addr[i-1];
      end
    end
  end

  always_comb begin
    sum_wide = '0;
    if (dl_first[TAP]) sum_wide = (ACC_WIDTH+1)'(dl_data[TAP]);
    else               sum_wide = {1'b0, bram_rdata} + (ACC_WIDTH+1)'(dl_data[TAP]);
    sum_ovf = sum_wide[ACC_WIDTH];
    sum_sat = sum_ovf ? '1 : sum_wide[ACC_WIDTH-1:0];
  end

  assign out_bin_last = (dl_addr[TAP][ADDR_W-1:2] == PERIOD_WIDTH'(PERIOD - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bram_we       <= 1'b0;
      bram_waddr    <= '0;
      bram_wdata    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      bram_we       <= dl_valid[TAP];
      bram_waddr    <= dl_addr[TAP];
      bram_wdata    <= sum_sat;
      m_axis_tvalid <= dl_valid[TAP] && dl_last[TAP];
      m_axis_tlast  <= dl_valid[TAP] && dl_last[TAP] && out_bin_last;
      if (dl_valid[TAP] && dl_last[TAP]) m_axis_tdata <= sum_sat;
      if (dl_valid[TAP] && sum_ovf)      overflow     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psd_accumulator.sv
// Directed bench for psd_accumulator: acts as the bin counter and the BRAM,
// checks emitted sums, tlast, latency, write counts and the overflow flag.
module tb_psd_accumulator;

  localparam int unsigned PERIOD = 8;
  localparam int unsigned PW     = 3;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned LAT    = 2;
  localparam int unsigned ADW    = PW + 2;

  logic           clk = 1'b0;
  logic           aresetn;
  logic           s_axis_tvalid;
  logic [DW-1:0]  s_axis_tdata;
  logic [ADW-1:0] addr;
  logic           first_cycle, last_cycle;
  logic [ADW-1:0] bram_raddr, bram_waddr;
  logic [AW-1:0]  bram_rdata, bram_wdata, m_axis_tdata;
  logic           bram_we, m_axis_tvalid, m_axis_tlast, overflow;

  psd_accumulator #(
    .PERIOD(PERIOD), .PERIOD_WIDTH(PW), .DATA_WIDTH(DW),
    .ACC_WIDTH(AW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .addr(addr), .first_cycle(first_cycle), .last_cycle(last_cycle),
    .bram_raddr(bram_raddr), .bram_rdata(bram_rdata),
    .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .bram_we(bram_we),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Dual-port BRAM with LAT-clock read latency, seeded with junk.
  logic [AW-1:0] mem   [PERIOD];
  logic [AW-1:0] rpipe [LAT];
  logic          seed_mem;

  always @(posedge clk) begin
    if (seed_mem) begin
      for (int i = 0; i < PERIOD; i++) mem[i] <= 32'hA5A50000 | 32'(i);
    end else if (bram_we) begin
      mem[bram_waddr[ADW-1:2]] <= bram_wdata;
    end
    rpipe[0] <= mem[bram_raddr[ADW-1:2]];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bram_rdata = rpipe[LAT-1];

  typedef struct {
    logic [AW-1:0] data;
    logic          last;
    int unsigned   t;
  } beat_t;

  int unsigned cyc = 0;
  int unsigned wr_cnt = 0;
  int unsigned exp_wr = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  beat_t obs_q[$];
  beat_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t ob;
    if (m_axis_tvalid) begin
      ob.data = m_axis_tdata;
      ob.last = m_axis_tlast;
      ob.t    = cyc;
      obs_q.push_back(ob);
    end
    if (bram_we) wr_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [ADW-1:0] pend_addr = '0;
  logic           pend_first = 1'b0;
  logic           pend_last = 1'b0;

  // Sideband trails its s_axis beat by one clock, as the counter produces it.
  task automatic drive(input logic v, input logic [DW-1:0] d, input int unsigned b,
                       input logic f, input logic l);
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    addr          = pend_addr;
    first_cycle   = pend_first;
    last_cycle    = pend_last;
    pend_addr     = ADW'(b << 2);
    pend_first    = f;
    pend_last     = l;
  endtask

  task automatic flush();
    repeat (8) drive(1'b0, '0, 0, 1'b0, 1'b0);
  endtask

  function automatic logic [AW-1:0] model_sum(input int unsigned ncyc, input logic [DW-1:0] d);
    longint unsigned s;
    s = longint'(ncyc) * longint'(d);
    if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
    return AW'(s);
  endfunction

  task automatic run(input int unsigned ncyc, input bit inc, input logic [DW-1:0] dval,
                     input bit gaps);
    logic [DW-1:0] d;
    beat_t eb;
    for (int unsigned c = 0; c < ncyc; c++) begin
      for (int unsigned b = 0; b < PERIOD; b++) begin
        d = inc ? DW'(b + 1) : dval;
        drive(1'b1, d, b, c == 0, c == ncyc - 1);
        exp_wr++;
        if (c == ncyc - 1) begin
          eb.data = model_sum(ncyc, d);
          eb.last = (b == PERIOD - 1);
          eb.t    = cyc + 2 + LAT;
          exp_q.push_back(eb);
        end
        if (gaps) drive(1'b0, '0, 0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic verify(input string tag);
    beat_t ob, eb;
    int unsigned k = 0;
    check({tag, ":n_out"}, obs_q.size(), exp_q.size());
    check({tag, ":n_wr"}, wr_cnt, exp_wr);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ob = obs_q.pop_front();
      eb = exp_q.pop_front();
      check($sformatf("%s:data[%0d]", tag, k), ob.data, eb.data);
      check($sformatf("%s:last[%0d]", tag, k), ob.last, eb.last);
      check($sformatf("%s:lat[%0d]", tag, k), ob.t, eb.t);
      k++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    aresetn = 1'b0;
    seed_mem = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    addr = 5'h1C;
    first_cycle = 1'b0;
    last_cycle = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:tvalid", m_axis_tvalid, 0);
    check("rst:tlast", m_axis_tlast, 0);
    check("rst:we", bram_we, 0);
    check("rst:ovf", overflow, 0);
    check("rst:waddr", bram_waddr, 0);
    check("rst:wdata", bram_wdata, 0);
    check("rst:raddr", bram_raddr, 0);
    addr = '0;
    seed_mem = 1'b0;
    aresetn = 1'b1;

    run(4, 1'b1, '0, 1'b0);
    flush();
    verify("ramp");
    check("ramp:ovf", overflow, 0);

    run(4, 1'b1, '0, 1'b1);
    flush();
    verify("gaps");
    check("gaps:ovf", overflow, 0);

    run(2, 1'b0, 32'hFFFF_FFFF, 1'b0);
    flush();
    verify("sat");
    check("sat:ovf", overflow, 1);

    run(1, 1'b0, 32'd5, 1'b0);
    flush();
    verify("single");
    for (int unsigned b = 0; b < PERIOD; b++)
      check($sformatf("single:mem[%0d]", b), mem[b], 32'd5);
    check("single:ovf_sticky", overflow, 1);

    // Reset mid-cycle 2, release at bin 3 of cycle 3: nothing may follow.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned b = 0; b < PERIOD; b++) begin
        drive(1'b1, 32'd7, b, c == 0, c == 3);
        if (c == 1 && b == 4) begin
          #2 aresetn = 1'b0;
          #1;
          check("mid:ovf", overflow, 0);
          check("mid:we", bram_we, 0);
          check("mid:tvalid", m_axis_tvalid, 0);
        end
        if (c == 2 && b == 3) begin
          aresetn = 1'b1;
          exp_wr = wr_cnt;
          obs_q.delete();
        end
      end
    end
    flush();
    verify("idle");
    check("idle:ovf", overflow, 0);

    run(2, 1'b0, 32'd3, 1'b0);
    flush();
    verify("rearm");

    run(2, 1'b0, 32'd1, 1'b0);
    run(2, 1'b0, 32'd2, 1'b0);
    flush();
    verify("b2b");
    check("b2b:ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
